// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// alu_pkg
// Shared definitions for the ALU issue/writeback stage (alu_op_sequencer)
// and its register file:
//   - default data / register-address widths and register count
//   - ALU opcode encodings OP_ADD .. OP_SHR
//   - sequencer FSM state encoding
//   - bit positions inside the 2-bit {z,c} flag vector
package alu_pkg;

  localparam int DW_DEF   = 4;
  localparam int NREG_DEF = 4;
  localparam int AW_DEF   = 2;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } seq_state_e;

  localparam int FLAG_Z = 1;
  localparam int FLAG_C = 0;

endpackage

// File: rtl/alu_regfile.sv
`timescale 1ns/1ps
// alu_regfile
// NREG x DW register file: two combinational read ports, one synchronous
// write port, synchronous active-high reset that clears every entry.
// Ports:
//   clk, rst          clock / synchronous active-high reset
//   we, waddr, wdata  write port (takes effect at the rising edge)
//   raddr_a, rdata_a  combinational read port A
//   raddr_b, rdata_b  combinational read port B
// Reads return the pre-edge contents, so a read and a write to the same
// entry in one cycle sees the old value.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr_a,
  output logic [DW-1:0] rdata_a,
  input  logic [AW-1:0] raddr_b,
  output logic [DW-1:0] rdata_b
);

  logic [DW-1:0] mem [NREG];

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the storage is reset because its post-reset contents are
      // architecturally visible; this keeps it as flops rather than a RAM.
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = mem[raddr_a];
  assign rdata_b = mem[raddr_b];

endmodule

// File: rtl/alu_op_sequencer.sv
`timescale 1ns/1ps
// alu_op_sequencer
// Issue/writeback stage sitting directly upstream of the 4-bit combinational
// ALU. Accepts an instruction, reads its operands from alu_regfile, drives the
// ALU for one cycle, writes the ALU result back and offers it downstream.
// Ports:
//   clk, rst                       clock / synchronous active-high reset
//   in_valid, in_ready             instruction handshake
//   in_op, in_srca, in_srcb,       opcode and register indices
//   in_dst
//   in_use_imm, in_imm             immediate B operand (see macro below)
//   cfg_we, cfg_addr, cfg_data     register preload, honoured only in IDLE
//   alu_a, alu_b, alu_opcode       to the external ALU
//   alu_res, alu_flag              from the external ALU ({z,c})
//   out_valid, out_ready           result handshake
//   out_res, out_flag, out_dst     captured result, flags, written register
// Configuration macro:
//   ALU_SEQ_IMM_EN  when defined, in_use_imm=1 at accept selects in_imm as
//                   the B operand; otherwise B always comes from rf[srcb].
// Flow: IDLE -(accept)-> EXEC -> RESP -(out_ready)-> IDLE. The writeback
// happens on the EXEC->RESP edge, so the next instruction always reads it.
module alu_op_sequencer
  import alu_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = AW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_op,
  input  logic [AW-1:0] in_srca,
  input  logic [AW-1:0] in_srcb,
  input  logic [AW-1:0] in_dst,
  input  logic          in_use_imm,
  input  logic [DW-1:0] in_imm,
  input  logic          cfg_we,
  input  logic [AW-1:0] cfg_addr,
  input  logic [DW-1:0] cfg_data,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [2:0]    alu_opcode,
  input  logic [DW-1:0] alu_res,
  input  logic [1:0]    alu_flag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_res,
  output logic [1:0]    out_flag,
  output logic [AW-1:0] out_dst
);

  seq_state_e    state_q, state_d;
  logic [DW-1:0] a_q, b_q;
  logic [2:0]    op_q;
  logic [AW-1:0] dst_q;

  logic [DW-1:0] rd_a, rd_b, b_sel;
  logic          accept;
  logic          rf_we;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  assign accept = in_valid & in_ready;

`ifdef ALU_SEQ_IMM_EN
  assign b_sel = in_use_imm ? in_imm : rd_b;
`else
  // Immediate ports stay on the interface but have no effect in this build.
  logic unused_imm;
  assign unused_imm = ^{in_use_imm, in_imm};
  assign b_sel      = rd_b;
`endif

  // Next-state logic.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Operand latches: sampled at the accept edge and held through EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      op_q  <= '0;
      dst_q <= '0;
    end else if (accept) begin
      a_q   <= rd_a;
      b_q   <= b_sel;
      op_q  <= in_op;
      dst_q <= in_dst;
    end
  end

  // Result capture on the EXEC->RESP edge; held for the whole RESP state.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_res  <= '0;
      out_flag <= '0;
      out_dst  <= '0;
    end else if (state_q == EXEC) begin
      out_res  <= alu_res;
      out_flag <= alu_flag;
      out_dst  <= dst_q;
    end
  end

  // Register-file write mux: writeback in EXEC, preload only in IDLE.
  // Reset inside the register file overrides both, so an aborted EXEC
  // never writes back.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = '0;
    rf_wdata = '0;
    if (state_q == EXEC) begin
      rf_we    = 1'b1;
      rf_waddr = dst_q;
      rf_wdata = alu_res;
    end else if (state_q == IDLE && cfg_we) begin
      rf_we    = 1'b1;
      rf_waddr = cfg_addr;
      rf_wdata = cfg_data;
    end
  end

  alu_regfile #(
    .DW   (DW),
    .NREG (NREG),
    .AW   (AW)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (rf_we),
    .waddr   (rf_waddr),
    .wdata   (rf_wdata),
    .raddr_a (in_srca),
    .rdata_a (rd_a),
    .raddr_b (in_srcb),
    .rdata_b (rd_b)
  );

  // Outputs are forced quiet while rst is high, even before the reset edge
  // has cleared the state and latches.
  assign in_ready   = ~rst & (state_q == IDLE);
  assign out_valid  = ~rst & (state_q == RESP);
  assign alu_a      = rst ? '0 : a_q;
  assign alu_b      = rst ? '0 : b_q;
  assign alu_opcode = rst ? 3'b000 : op_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
`timescale 1ns/1ps
// tb_alu_op_sequencer
// Self-checking bench for alu_op_sequencer. A behavioural 4-bit ALU sits
// beside the DUT. A table of instructions with hand-computed operands and
// results is issued back to back; expected results go into a scoreboard
// queue at accept and are popped at the output handshake. Hand-written
// sequences cover back-pressure, same-cycle preload, abort by reset and the
// immediate operand.
module tb_alu_op_sequencer;
  import alu_pkg::*;

  localparam int DW   = 4;
  localparam int NREG = 4;
  localparam int AW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [2:0]    in_op;
  logic [AW-1:0] in_srca, in_srcb, in_dst;
  logic          in_use_imm;
  logic [DW-1:0] in_imm;
  logic          cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [DW-1:0] cfg_data;
  logic [DW-1:0] alu_a, alu_b, alu_res;
  logic [2:0]    alu_opcode;
  logic [1:0]    alu_flag;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_res;
  logic [1:0]    out_flag;
  logic [AW-1:0] out_dst;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  alu_op_sequencer #(.DW(DW), .NREG(NREG), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_srca    (in_srca),
    .in_srcb    (in_srcb),
    .in_dst     (in_dst),
    .in_use_imm (in_use_imm),
    .in_imm     (in_imm),
    .cfg_we     (cfg_we),
    .cfg_addr   (cfg_addr),
    .cfg_data   (cfg_data),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_res    (alu_res),
    .alu_flag   (alu_flag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_flag   (out_flag),
    .out_dst    (out_dst)
  );

  // Behavioural ALU: flag = {zero, carry/borrow/shifted-out bit}.
  logic [DW:0]   alu_t;
  logic [DW-1:0] alu_r;
  logic          alu_c;
  always_comb begin
    alu_t = '0;
    alu_r = '0;
    alu_c = 1'b0;
    case (alu_opcode)
      OP_ADD: begin alu_t = {1'b0, alu_a} + {1'b0, alu_b}; alu_r = alu_t[DW-1:0]; alu_c = alu_t[DW]; end
      OP_SUB: begin alu_t = {1'b0, alu_a} - {1'b0, alu_b}; alu_r = alu_t[DW-1:0]; alu_c = alu_t[DW]; end
      OP_AND: alu_r = alu_a & alu_b;
      OP_OR:  alu_r = alu_a | alu_b;
      OP_XOR: alu_r = alu_a ^ alu_b;
      OP_NOT: alu_r = ~alu_a;
      OP_SHL: begin alu_r = {alu_a[DW-2:0], 1'b0}; alu_c = alu_a[DW-1]; end
      OP_SHR: begin alu_r = {1'b0, alu_a[DW-1:1]}; alu_c = alu_a[0]; end
      default: alu_r = '0;
    endcase
    alu_res  = alu_r;
    alu_flag = {(alu_r == '0), alu_c};
  end

  typedef struct {
    logic [2:0]    op;
    logic [AW-1:0] sa, sb, dst;
    logic          use_imm;
    logic [DW-1:0] imm;
    logic [DW-1:0] ea, eb, eres;
    logic [1:0]    eflag;
  } vec_t;

  typedef struct {
    logic [DW-1:0] res;
    logic [1:0]    flag;
    logic [AW-1:0] dst;
  } exp_t;

  exp_t sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cfg_we   = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    tick();
    cfg_we   = 1'b0;
  endtask

  // Issue one instruction and retire it. pre_* drives a preload in the
  // accept cycle; during a stall a preload to R3 is attempted every cycle.
  task automatic issue(input vec_t v, input int stall, input logic pre_we,
                       input logic [AW-1:0] pre_a, input logic [DW-1:0] pre_d,
                       output int acc_cycle);
    int   n;
    exp_t e;
    acc_cycle  = -1;
    in_valid   = 1'b1;
    in_op      = v.op;
    in_srca    = v.sa;
    in_srcb    = v.sb;
    in_dst     = v.dst;
    in_use_imm = v.use_imm;
    in_imm     = v.imm;
    cfg_we     = pre_we;
    cfg_addr   = pre_a;
    cfg_data   = pre_d;
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      cfg_we   = 1'b0;
      return;
    end
    tick();
    acc_cycle = cyc;
    in_valid  = 1'b0;
    cfg_we    = 1'b0;
    e.res  = v.eres;
    e.flag = v.eflag;
    e.dst  = v.dst;
    sb_q.push_back(e);
    check("exec_alu_a", 32'(alu_a), 32'(v.ea));
    check("exec_alu_b", 32'(alu_b), 32'(v.eb));
    check("exec_opcode", 32'(alu_opcode), 32'(v.op));
    check("exec_in_ready", 32'(in_ready), 32'd0);
    out_ready = (stall == 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (!out_valid && n < 20);
    check("out_valid_latency", 32'(n), 32'd1);
    if (!out_valid) return;
    for (int i = 0; i < stall; i++) begin
      cfg_we   = 1'b1;
      cfg_addr = 2'd3;
      cfg_data = 4'hF;
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_res", 32'(out_res), 32'(v.eres));
      check("stall_out_flag", 32'(out_flag), 32'(v.eflag));
      tick();
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    #1;
    e = sb_q.pop_front();
    check("out_res", 32'(out_res), 32'(e.res));
    check("out_flag", 32'(out_flag), 32'(e.flag));
    check("out_dst", 32'(out_dst), 32'(e.dst));
    tick();
    check("resume_in_ready", 32'(in_ready), 32'd1);
    check("resume_out_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[8];
    vec_t h;
    int   acc, prev_acc;

    // op, sa, sb, dst, use_imm, imm, exp a, exp b, exp res, exp flag
    vt[0] = '{OP_ADD, 2'd0, 2'd1, 2'd2, 1'b0, 4'hF, 4'h7, 4'h9, 4'h0, 2'b11};
    vt[1] = '{OP_OR,  2'd2, 2'd2, 2'd2, 1'b0, 4'hF, 4'h0, 4'h0, 4'h0, 2'b10};
    vt[2] = '{OP_SUB, 2'd1, 2'd0, 2'd3, 1'b0, 4'hF, 4'h9, 4'h7, 4'h2, 2'b00};
    vt[3] = '{OP_SHL, 2'd0, 2'd0, 2'd0, 1'b0, 4'hF, 4'h7, 4'h7, 4'hE, 2'b00};
    vt[4] = '{OP_XOR, 2'd0, 2'd0, 2'd0, 1'b0, 4'hF, 4'hE, 4'hE, 4'h0, 2'b10};
    vt[5] = '{OP_ADD, 2'd3, 2'd3, 2'd1, 1'b0, 4'hF, 4'h2, 4'h2, 4'h4, 2'b00};
    vt[6] = '{OP_SHR, 2'd3, 2'd3, 2'd3, 1'b0, 4'hF, 4'h2, 4'h2, 4'h1, 2'b00};
    vt[7] = '{OP_SUB, 2'd3, 2'd1, 2'd2, 1'b0, 4'hF, 4'h1, 4'h4, 4'hD, 2'b01};

    rst = 1'b1; in_valid = 1'b0; in_op = '0; in_srca = '0; in_srcb = '0;
    in_dst = '0; in_use_imm = 1'b0; in_imm = '0; cfg_we = 1'b0;
    cfg_addr = '0; cfg_data = '0; out_ready = 1'b1;

    // Reset state.
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_res", 32'(out_res), 32'd0);
    check("reset_out_flag", 32'(out_flag), 32'd0);
    check("reset_out_dst", 32'(out_dst), 32'd0);
    check("reset_alu_a", 32'(alu_a), 32'd0);

    preload(2'd0, 4'h7);
    preload(2'd1, 4'h9);

    // Back-to-back table; each accept must follow the previous by 3 cycles.
    prev_acc = -1;
    for (int i = 0; i < 8; i++) begin
      issue(vt[i], 0, 1'b0, '0, '0, acc);
      if (prev_acc >= 0) check($sformatf("issue_interval_%0d", i), 32'(acc - prev_acc), 32'd3);
      prev_acc = acc;
    end

    // Preload in the accept cycle (operand reads old R2=D) plus a 5-cycle
    // stall during which a preload of R3 is attempted and must be ignored.
    h = '{OP_ADD, 2'd2, 2'd3, 2'd0, 1'b0, 4'h0, 4'hD, 4'h1, 4'hE, 2'b00};
    issue(h, 5, 1'b1, 2'd2, 4'h5, acc);
    h = '{OP_OR, 2'd2, 2'd3, 2'd1, 1'b0, 4'h0, 4'h5, 4'h1, 4'h5, 2'b00};
    issue(h, 0, 1'b0, '0, '0, acc);

    // Abort by reset during EXEC.
    in_valid = 1'b1; in_op = OP_AND; in_srca = 2'd1; in_srcb = 2'd1; in_dst = 2'd2;
    in_use_imm = 1'b0;
    tick();
    in_valid = 1'b0;
    check("abort_exec_opcode", 32'(alu_opcode), 32'(OP_AND));
    rst = 1'b1;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd0);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_alu_a", 32'(alu_a), 32'd0);
    check("abort_alu_b", 32'(alu_b), 32'd0);
    check("abort_alu_opcode", 32'(alu_opcode), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      check("after_rst_no_valid", 32'(out_valid), 32'd0);
      tick();
    end
    h = '{OP_OR, 2'd2, 2'd2, 2'd2, 1'b0, 4'h0, 4'h0, 4'h0, 4'h0, 2'b10};
    issue(h, 0, 1'b0, '0, '0, acc);

    // Immediate operand.
    preload(2'd1, 4'h9);
    preload(2'd2, 4'h5);
`ifdef ALU_SEQ_IMM_EN
    h = '{OP_OR, 2'd1, 2'd2, 2'd3, 1'b1, 4'h6, 4'h9, 4'h6, 4'hF, 2'b00};
`else
    h = '{OP_OR, 2'd1, 2'd2, 2'd3, 1'b1, 4'h6, 4'h9, 4'h5, 4'hD, 2'b00};
`endif
    issue(h, 0, 1'b0, '0, '0, acc);

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
